hilo_move_controller: RTL
=========================

# hilo_move_controller

Parametrised control-step sequencer for the datapath. It generates the fetch sequence (T0–T2) and the execute step (T3) for the move-to/from-special-register group: mfhi, mflo, mthi and mtlo. Each T-step has a configurable dwell length, and T1 waits on a memory-ready handshake. It sits between the IR opcode field and the datapath strobe inputs, and replaces hand-driven control sequencing.

## Interface
- OPCODE_W, 5, width of opcode field (IR[31:27])
- DWELL, 2, clocks each T-step is held; legal range 1..15
- OP_MFHI, 5'd23, opcode for mfhi
- OP_MFLO, 5'd24, opcode for mflo
- OP_MTHI, 5'd25, opcode for mthi
- OP_MTLO, 5'd26, opcode for mtlo

Ports:
- Clock  in  1  single system clock; all state changes on its rising edge
- clear  in  1  reset, asynchronous and active-high
- run  in  1  level; while high the sequencer fetches and executes continuously
- opcode  in  OPCODE_W  IR opcode field
- mem_ready  in  1  memory read data valid
- PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC  out  1 each  fetch strobes
- Gra, Rin, Rout, HIout, LOout, HIin, LOin  out  1 each  execute strobes
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the last cycle of T3
- illegal  out  1  one-cycle pulse on the last cycle of T3 when the opcode is not in the group

## Operation
- States: IDLE, T0, T1, T2, T3. A dwell counter, ceil(log2(DWELL+1)) bits, resets to 0 on every state entry.
- IDLE: all strobes are 0. Enter T0 on the first edge that samples run=1.
- T0: PCout=1, MARin=1.
- T1: MDRin=1, Read=1.
  - Exit to T2 only when the dwell has expired **and** mem_ready=1 is sampled.
  - Otherwise hold T1 with strobes steady; the counter saturates.
- T2: MDRout=1, IRin=1, PCin=1, IncPC=1.
- T3: opcode is captured into a register on the T2→T3 edge and held stable through T3. Strobes by captured opcode:
  - OP_MFLO: Gra, Rin, LOout.
  - OP_MFHI: Gra, Rin, HIout.
  - OP_MTHI: Gra, Rout, HIin.
  - OP_MTLO: Gra, Rout, LOin.
  - Any other opcode: no execute strobes. illegal pulses on the last T3 cycle.
- T3 exit: to T0 if run=1 is sampled on the final T3 cycle, else to IDLE.
- run falling mid-instruction does not abort; the instruction completes through T3.
- Strobes and status are a Moore decode of registered state only. No input reaches an output combinationally.
- At most one of Rin/Rout is high at any time. At most one of HIout/LOout/HIin/LOin is high at any time. Bench checks both as assertions.

## Timing
- Reset value of every output is 0. State is IDLE and the counter is 0.
- clear asserted at any point, including mid-T1 wait or mid-T3, forces the reset values immediately, without waiting for a clock edge.
- After clear deasserts, the first edge with run=1 enters T0.
- Each step other than T1 lasts exactly DWELL cycles.
- T1 lasts DWELL + W cycles, where W is the number of dwell-expired cycles with mem_ready=0.
- Instruction latency from T0 entry to done pulse = 4·DWELL + W cycles.
- With run held high, T0 of the next instruction follows T3 with no bubble.
- mem_ready high during the dwell count has no early effect. mem_ready is ignored outside T1.
- DWELL=1: every step is one cycle, and T1 exits on the same edge that samples mem_ready=1.
- done and illegal are never high outside T3. When the opcode is illegal, both pulse together.

## Test plan
- Reset: pulse clear between edges -> all outputs 0 asynchronously; with run=0, remain IDLE for 10 cycles.
- mflo, DWELL=2, mem_ready=1, opcode=24 -> PCout/MARin cycles 1–2; Read/MDRin cycles 3–4; IRin/PCin/IncPC cycles 5–6; Gra/Rin/LOout cycles 7–8; done on cycle 8; busy low on cycle 9 when run is already 0.
- Memory wait: mfhi, mem_ready low until 3 cycles after T1 dwell expiry -> T1 held 5 cycles with strobes steady; done on cycle 11; HIout is the only special-register strobe.
- Illegal opcode 5'd3 -> no Rin/Rout/HI/LO strobe; illegal and done pulse together on the last T3 cycle.
- Back-to-back mthi then mtlo with run held high -> second T0 immediately follows first T3; Rout/HIin then Rout/LOin; two done pulses 8 cycles apart.
- clear asserted in the 2nd T1 wait cycle -> outputs 0 immediately; after release with run=1, a full fetch restarts at T0.

Source files
------------

// File: rtl/hilo_move_controller_if.sv
// Opcode/handshake inputs and datapath strobe outputs of the mfhi/mflo/mthi/mtlo control sequencer.
interface hilo_move_controller_if #(
  parameter int OPCODE_W = 5
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC;
  logic Gra, Rin, Rout, HIout, LOout, HIin, LOin;
  logic busy, done, illegal;

  modport master (
    output run, opcode, mem_ready,
    input  PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC,
    input  Gra, Rin, Rout, HIout, LOout, HIin, LOin,
    input  busy, done, illegal
  );

  modport slave (
    input  run, opcode, mem_ready,
    output PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC,
    output Gra, Rin, Rout, HIout, LOout, HIin, LOin,
    output busy, done, illegal
  );
endinterface

// File: rtl/hilo_move_controller.sv
// Fetch (T0-T2) and execute (T3) step sequencer for the HI/LO move instruction group.
//   state | meaning
//   IDLE  | waiting for run, all strobes low
//   T0    | PC -> MAR
//   T1    | memory read into MDR, held until dwell expired and mem_ready
//   T2    | MDR -> IR, PC increment
//   T3    | execute the captured HI/LO move opcode
module hilo_move_controller #(
  parameter int                  OPCODE_W = 5,
  parameter int                  DWELL    = 2,
  parameter logic [OPCODE_W-1:0] OP_MFHI  = 5'd23,
  parameter logic [OPCODE_W-1:0] OP_MFLO  = 5'd24,
  parameter logic [OPCODE_W-1:0] OP_MTHI  = 5'd25,
  parameter logic [OPCODE_W-1:0] OP_MTLO  = 5'd26
) (
  input logic                     Clock,
  input logic                     clear,
  hilo_move_controller_if.slave   bus
);
  localparam int            CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [OPCODE_W-1:0] op_q, op_n;
  logic                last;
  logic                t3_n, last_n, grp_n;
  logic                mfhi_n, mflo_n, mthi_n, mtlo_n;

  assign last = (cnt == LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (bus.run) state_n = S_T0;
      end
      S_T0: begin
        if (last) begin
          state_n = S_T1;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
      end
      // counter saturates at LAST while waiting for memory
      S_T1: begin
        if (last) begin
          if (bus.mem_ready) begin
            state_n = S_T2;
            cnt_n   = '0;
          end
        end else cnt_n = cnt + CW'(1);
      end
      S_T2: begin
        if (last) begin
          state_n = S_T3;
          cnt_n   = '0;
          op_n    = bus.opcode;
        end else cnt_n = cnt + CW'(1);
      end
      S_T3: begin
        if (last) begin
          state_n = bus.run ? S_T0 : S_IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they track the state register exactly.
  always_comb begin
    t3_n   = (state_n == S_T3);
    last_n = (cnt_n == LAST);
    mfhi_n = t3_n && (op_n == OP_MFHI);
    mflo_n = t3_n && (op_n == OP_MFLO);
    mthi_n = t3_n && (op_n == OP_MTHI);
    mtlo_n = t3_n && (op_n == OP_MTLO);
    grp_n  = mfhi_n || mflo_n || mthi_n || mtlo_n;
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      bus.PCout   <= 1'b0;
      bus.MARin   <= 1'b0;
      bus.MDRin   <= 1'b0;
      bus.Read    <= 1'b0;
      bus.MDRout  <= 1'b0;
      bus.IRin    <= 1'b0;
      bus.PCin    <= 1'b0;
      bus.IncPC   <= 1'b0;
      bus.Gra     <= 1'b0;
      bus.Rin     <= 1'b0;
      bus.Rout    <= 1'b0;
      bus.HIout   <= 1'b0;
      bus.LOout   <= 1'b0;
      bus.HIin    <= 1'b0;
      bus.LOin    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op_q        <= op_n;
      bus.PCout   <= (state_n == S_T0);
      bus.MARin   <= (state_n == S_T0);
      bus.MDRin   <= (state_n == S_T1);
      bus.Read    <= (state_n == S_T1);
      bus.MDRout  <= (state_n == S_T2);
      bus.IRin    <= (state_n == S_T2);
      bus.PCin    <= (state_n == S_T2);
      bus.IncPC   <= (state_n == S_T2);
      bus.Gra     <= grp_n;
      bus.Rin     <= mfhi_n || mflo_n;
      bus.Rout    <= mthi_n || mtlo_n;
      bus.HIout   <= mfhi_n;
      bus.LOout   <= mflo_n;
      bus.HIin    <= mthi_n;
      bus.LOin    <= mtlo_n;
      bus.busy    <= (state_n != S_IDLE);
      bus.done    <= t3_n && last_n;
      bus.illegal <= t3_n && last_n && !grp_n;
    end
  end
endmodule
